fetch_unit: RTL



---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-issue core.
// Owns the PC and drives the word address of a combinational instruction memory. Each fetched
// word is registered into the IF/ID register and presented to the decoder under valid/ready.
// Handles back-pressure, redirects with flush, and halts on an all-zero word or an illegal PC.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_addr_o        word index into instruction memory ({2'b00, pc[31:2]})
//   imem_instr_i       instruction word for imem_addr_o (combinational)
//   id_valid_o         IF/ID register holds an instruction
//   id_ready_i         decoder accepts the IF/ID contents this cycle
//   id_instr_o         registered instruction
//   id_pc_o            byte address of id_instr_o
//   redirect_valid_i   taken branch/jump pulse
//   redirect_pc_i      byte target of the redirect
//   halted_o           fetching has stopped
//   fetch_err_o        halt caused by a misaligned or out-of-range PC
//   fetch_count_o      instructions loaded into IF/ID (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1280
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        halted_o,
    output logic        fetch_err_o,
    output logic [15:0] fetch_count_o
);

    localparam logic [29:0] MemWordsW = 30'(MEM_WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic accept;
    logic pc_illegal;

    assign accept     = !id_valid_q || id_ready_i;
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= MemWordsW);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        fetch_err_d   = fetch_err_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid_i) begin
            // Redirect wins in every state and flushes IF/ID even if the decoder is consuming.
            pc_d        = redirect_pc_i;
            id_valid_d  = 1'b0;
            state_d     = StRun;
            fetch_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StRun;
                StRun: begin
                    if (accept) begin
                        if (pc_illegal) begin
                            state_d     = StHalt;
                            fetch_err_d = 1'b1;
                            id_valid_d  = 1'b0;
                        end else if (imem_instr_i == 32'h0) begin
                            // Zero word marks end of program: not loaded, PC holds.
                            state_d    = StHalt;
                            id_valid_d = 1'b0;
                        end else begin
                            id_instr_d    = imem_instr_i;
                            id_pc_d       = pc_q;
                            id_valid_d    = 1'b1;
                            pc_d          = pc_q + 32'd4;
                            fetch_count_d = fetch_count_q + 16'd1;
                        end
                    end
                end
                StHalt: begin
                    if (id_ready_i) id_valid_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_q       <= 32'h0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            fetch_err_q   <= fetch_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr_o   = {2'b00, pc_q[31:2]};
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_o       = id_pc_q;
    assign halted_o      = (state_q == StHalt);
    assign fetch_err_o   = fetch_err_q;
    assign fetch_count_o = fetch_count_q;

endmodule
